// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus writeback result selection.
// Registers the memory-stage results and selects the register-file write data.
// Load data is extracted by byte/halfword lane and then sign- or zero-extended.
// Drives the register-file write port and the forwarding bus.
// Optional feature macro: RETIRE_COUNT_EN adds a 64-bit retired-instruction counter.
module writeback_stage #(
    parameter int                 XLEN      = 32,
    parameter int                 REG_AW    = 5,
    parameter logic [XLEN-1:0]    RESET_PC4 = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_m,
    input  logic                  reg_write_m,
    input  logic [REG_AW-1:0]     rd_m,
    input  logic [1:0]            result_src_m,
    input  logic [2:0]            funct3_m,
    input  logic [XLEN-1:0]       alu_result_m,
    input  logic [XLEN-1:0]       read_data_m,
    input  logic [XLEN-1:0]       pc_plus4_m,
    input  logic [XLEN-1:0]       imm_ext_m,
    output logic                  valid_w,
    output logic                  reg_write_w,
    output logic [REG_AW-1:0]     rd_w,
    output logic [XLEN-1:0]       result_w,
    output logic                  misalign_w
`ifdef RETIRE_COUNT_EN
    ,
    output logic [63:0]           retire_count
`endif
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_IMM  = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic                 valid_q;
    logic                 reg_write_q;
    logic [REG_AW-1:0]    rd_q;
    result_src_e          result_src_q;
    logic [2:0]           funct3_q;
    logic [XLEN-1:0]      alu_q;
    logic [XLEN-1:0]      rdata_q;
    logic [XLEN-1:0]      pc4_q;
    logic [XLEN-1:0]      imm_q;

    logic [31:0]          word;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [XLEN-1:0]      load_data;
    logic                 misalign;

    // WB pipeline register: flush beats stall beats normal capture.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            result_src_q <= SRC_ALU;
            funct3_q     <= 3'b000;
            alu_q        <= '0;
            rdata_q      <= '0;
            pc4_q        <= RESET_PC4;
            imm_q        <= '0;
        end else if (flush_i) begin
            // Bubble: only the control bits matter, data fields simply hold.
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
        end else if (!stall_i) begin
            valid_q      <= valid_m;
            reg_write_q  <= reg_write_m;
            rd_q         <= rd_m;
            result_src_q <= result_src_e'(result_src_m);
            funct3_q     <= funct3_m;
            alu_q        <= alu_result_m;
            rdata_q      <= read_data_m;
            pc4_q        <= pc_plus4_m;
            imm_q        <= imm_ext_m;
        end
    end

    assign word     = rdata_q[31:0];
    assign half_sel = alu_q[1] ? word[31:16] : word[15:0];

    // Load lane extraction, extension and misalignment detection from registered fields.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        byte_sel  = word[7:0];
        load_data = XLEN'($signed(word));
        misalign  = 1'b0;
        case (alu_q[1:0])
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            2'b11:   byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        case (funct3_q)
            F3_LB:   load_data = XLEN'($signed(byte_sel));
            F3_LH:   load_data = XLEN'($signed(half_sel));
            F3_LBU:  load_data = XLEN'(byte_sel);
            F3_LHU:  load_data = XLEN'(half_sel);
            default: load_data = XLEN'($signed(word));
        endcase
        if (valid_q && result_src_q == SRC_LOAD) begin
            case (funct3_q)
                F3_LB, F3_LBU: misalign = 1'b0;
                F3_LH, F3_LHU: misalign = alu_q[0];
                default:       misalign = (alu_q[1:0] != 2'b00);
            endcase
        end
    end

    // Writeback result source selection.
    always_comb begin
        result_w = alu_q;
        case (result_src_q)
            SRC_ALU:  result_w = alu_q;
            SRC_LOAD: result_w = load_data;
            SRC_PC4:  result_w = pc4_q;
            SRC_IMM:  result_w = imm_q;
            default:  result_w = alu_q;
        endcase
    end

    assign valid_w     = valid_q;
    assign rd_w        = rd_q;
    assign misalign_w  = misalign;
    assign reg_write_w = valid_q & reg_write_q & (rd_q != '0) & ~misalign;

`ifdef RETIRE_COUNT_EN
    // Count instructions leaving WB: valid, not stalled, not a faulting load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_count <= 64'd0;
        end else if (valid_q && !stall_i && !misalign) begin
            retire_count <= retire_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed-vector bench for writeback_stage with hand-computed results.
// Optional feature macro: RETIRE_COUNT_EN enables the retire counter checks.
module tb_writeback_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              rst;
    logic              stall_i;
    logic              flush_i;
    logic              valid_m;
    logic              reg_write_m;
    logic [REG_AW-1:0] rd_m;
    logic [1:0]        result_src_m;
    logic [2:0]        funct3_m;
    logic [XLEN-1:0]   alu_result_m;
    logic [XLEN-1:0]   read_data_m;
    logic [XLEN-1:0]   pc_plus4_m;
    logic [XLEN-1:0]   imm_ext_m;
    logic              valid_w;
    logic              reg_write_w;
    logic [REG_AW-1:0] rd_w;
    logic [XLEN-1:0]   result_w;
    logic              misalign_w;
`ifdef RETIRE_COUNT_EN
    logic [63:0]       retire_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    writeback_stage #(
        .XLEN      (XLEN),
        .REG_AW    (REG_AW),
        .RESET_PC4 (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .rd_m         (rd_m),
        .result_src_m (result_src_m),
        .funct3_m     (funct3_m),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .imm_ext_m    (imm_ext_m),
        .valid_w      (valid_w),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_w     (result_w),
        .misalign_w   (misalign_w)
`ifdef RETIRE_COUNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic rw, input logic mis,
                             input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] res);
        check({tag, ".valid"},    64'(valid_w),     64'(v));
        check({tag, ".regwrite"}, 64'(reg_write_w), 64'(rw));
        check({tag, ".misalign"}, 64'(misalign_w),  64'(mis));
        check({tag, ".rd"},       64'(rd_w),        64'(rd));
        check({tag, ".result"},   64'(result_w),    64'(res));
    endtask

    task automatic drive(input logic v, input logic rw, input logic [REG_AW-1:0] rd,
                         input logic [1:0] src, input logic [2:0] f3, input logic [XLEN-1:0] alu,
                         input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] pc4,
                         input logic [XLEN-1:0] imm);
        valid_m      = v;
        reg_write_m  = rw;
        rd_m         = rd;
        result_src_m = src;
        funct3_m     = f3;
        alu_result_m = alu;
        read_data_m  = rdata;
        pc_plus4_m   = pc4;
        imm_ext_m    = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        rst     = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
        #2;
        check_out("reset", 0, 0, 0, 0, 32'h0);
`ifdef RETIRE_COUNT_EN
        check("reset.retire", retire_count, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // ALU op
        drive(1, 1, 5, 2'b00, 3'b000, 32'h0000_1234, 0, 32'h10, 0);
        step();
        check_out("alu", 1, 1, 0, 5, 32'h0000_1234);

        // Byte/halfword extraction from RD = 0x80FF_7F01
        drive(1, 1, 6, 2'b01, 3'b000, 32'h0000_0003, RD, 0, 0); step();
        check_out("lb_a3", 1, 1, 0, 6, 32'hFFFF_FF80);
        drive(1, 1, 6, 2'b01, 3'b100, 32'h0000_0003, RD, 0, 0); step();
        check_out("lbu_a3", 1, 1, 0, 6, 32'h0000_0080);
        drive(1, 1, 6, 2'b01, 3'b000, 32'h0000_0001, RD, 0, 0); step();
        check_out("lb_a1", 1, 1, 0, 6, 32'h0000_007F);
        drive(1, 1, 6, 2'b01, 3'b000, 32'h0000_0002, RD, 0, 0); step();
        check_out("lb_a2", 1, 1, 0, 6, 32'hFFFF_FFFF);
        drive(1, 1, 6, 2'b01, 3'b100, 32'h0000_0000, RD, 0, 0); step();
        check_out("lbu_a0", 1, 1, 0, 6, 32'h0000_0001);
        drive(1, 1, 8, 2'b01, 3'b001, 32'h0000_0002, RD, 0, 0); step();
        check_out("lh_a2", 1, 1, 0, 8, 32'hFFFF_80FF);
        drive(1, 1, 8, 2'b01, 3'b101, 32'h0000_0002, RD, 0, 0); step();
        check_out("lhu_a2", 1, 1, 0, 8, 32'h0000_80FF);
        drive(1, 1, 8, 2'b01, 3'b001, 32'h0000_0000, RD, 0, 0); step();
        check_out("lh_a0", 1, 1, 0, 8, 32'h0000_7F01);

        // Misalignment
        drive(1, 1, 10, 2'b01, 3'b010, 32'h0000_1002, RD, 0, 0); step();
        check_out("lw_mis", 1, 0, 1, 10, RD);
        drive(1, 1, 10, 2'b01, 3'b101, 32'h0000_1001, RD, 0, 0); step();
        check_out("lhu_mis", 1, 0, 1, 10, 32'h0000_7F01);
        drive(1, 1, 10, 2'b01, 3'b101, 32'h0000_1000, RD, 0, 0); step();
        check_out("lhu_ok", 1, 1, 0, 10, 32'h0000_7F01);
        drive(1, 1, 10, 2'b01, 3'b010, 32'h0000_1000, RD, 0, 0); step();
        check_out("lw_ok", 1, 1, 0, 10, RD);
        drive(1, 1, 11, 2'b01, 3'b011, 32'h0000_1000, RD, 0, 0); step();
        check_out("f3_011_ok", 1, 1, 0, 11, RD);
        drive(1, 1, 11, 2'b01, 3'b011, 32'h0000_1001, RD, 0, 0); step();
        check_out("f3_011_mis", 1, 0, 1, 11, RD);
        drive(0, 1, 11, 2'b01, 3'b010, 32'h0000_1001, RD, 0, 0); step();
        check_out("invalid_mis", 0, 0, 0, 11, RD);
        drive(1, 1, 12, 2'b00, 3'b001, 32'h0000_1001, RD, 0, 0); step();
        check_out("alu_oddaddr", 1, 1, 0, 12, 32'h0000_1001);

        // PC+4, immediate, write suppression
        drive(1, 1, 0, 2'b10, 3'b000, 32'h0000_0040, 0, 32'h0000_0104, 0); step();
        check_out("jal_x0", 1, 0, 0, 0, 32'h0000_0104);
        drive(1, 1, 13, 2'b11, 3'b000, 32'h0000_0040, 0, 32'h0000_0104, 32'hABCD_E000); step();
        check_out("lui", 1, 1, 0, 13, 32'hABCD_E000);
        drive(1, 0, 13, 2'b00, 3'b000, 32'h0000_0077, 0, 0, 0); step();
        check_out("no_rw", 1, 0, 0, 13, 32'h0000_0077);

        // Stall holds load A while different inputs are presented
        drive(1, 1, 7, 2'b01, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 0, 0); step();
        check_out("load_a", 1, 1, 0, 7, 32'hDEAD_BEEF);
        drive(1, 1, 9, 2'b00, 3'b000, 32'h0000_5555, 0, 0, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("stall%0d", i), 1, 1, 0, 7, 32'hDEAD_BEEF);
        end
        flush_i = 1'b1;
        step();
        check("flush_stall.valid", 64'(valid_w), 64'd0);
        check("flush_stall.regwrite", 64'(reg_write_w), 64'd0);
        flush_i = 1'b0;
        stall_i = 1'b0;
        step();
        check_out("after_stall", 1, 1, 0, 9, 32'h0000_5555);

        // Async reset mid-cycle
        drive(1, 1, 14, 2'b00, 3'b000, 32'h0000_0999, 0, 0, 0); step();
        check_out("pre_rst", 1, 1, 0, 14, 32'h0000_0999);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0, 32'h0);
`ifdef RETIRE_COUNT_EN
        check("async_rst.retire", retire_count, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

`ifdef RETIRE_COUNT_EN
        // Three valid instructions retire; misaligned load and bubbles do not count.
        drive(1, 1, 1, 2'b00, 3'b000, 32'h1, 0, 0, 0); step();
        drive(1, 1, 2, 2'b00, 3'b000, 32'h2, 0, 0, 0); step();
        drive(1, 1, 3, 2'b00, 3'b000, 32'h3, 0, 0, 0); step();
        check("retire.two", retire_count, 64'd2);
        drive(1, 1, 4, 2'b01, 3'b010, 32'h2, RD, 0, 0); step();
        check("retire.three", retire_count, 64'd3);
        drive(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0); step();
        check("retire.mis_skipped", retire_count, 64'd3);
        step();
        check("retire.bubble_skipped", retire_count, 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
